// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: counter slot indices
// and default geometry.
package perf_pkg;

  localparam int unsigned CNT_CYCLES = 32'd0;
  localparam int unsigned CNT_INSTR  = 32'd1;
  localparam int unsigned CNT_STALL  = 32'd2;
  localparam int unsigned CNT_LOAD   = 32'd3;
  localparam int unsigned CNT_STORE  = 32'd4;
  localparam int unsigned CNT_ALU    = 32'd5;
  localparam int unsigned CNT_CTRL   = 32'd6;
  localparam int unsigned CNT_SPARE  = 32'd7;

  localparam int unsigned DEF_NUM_CNT = 32'd8;
  localparam int unsigned DEF_CNT_W   = 32'd16;
  localparam int unsigned DEF_INC_W   = 32'd2;

endpackage

// File: rtl/perf_counter_cell.sv
// One performance counter: multi-bit increment with wrap or saturate, software
// write, synchronous clear, sticky overflow flag and snapshot shadow register.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int INC_W    = DEF_INC_W,
  parameter int ADDR_W   = 4,
  parameter int IDX      = 0,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clrAll,
  input  logic [INC_W-1:0]  inc,
  input  logic              snap,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [CNT_W-1:0]  wrData,
  output logic [CNT_W-1:0]  cnt,
  output logic [CNT_W-1:0]  shadow,
  output logic              ovf
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] shadow_r;
  logic             ovf_r;
  logic [CNT_W-1:0] nextCnt_s;
  logic             nextOvf_s;
  logic [CNT_W:0]   sum_s;
  logic             wrHit_s;

  assign wrHit_s = wrEn && (wrAddr == ADDR_W'(IDX));
  // The extra top bit of the sum is the carry-out that raises the overflow flag.
  assign sum_s   = {1'b0, cnt_r} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};

  // Next-state selection: clear beats write beats increment.
  always_comb begin
    nextCnt_s = cnt_r;
    nextOvf_s = ovf_r;
    if (clrAll) begin
      nextCnt_s = {CNT_W{1'b0}};
      nextOvf_s = 1'b0;
    end else if (wrHit_s) begin
      nextCnt_s = wrData;
    end else if (en) begin
      if (sum_s[CNT_W]) begin
        nextOvf_s = 1'b1;
        nextCnt_s = (SATURATE != 0) ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
      end else begin
        nextCnt_s = sum_s[CNT_W-1:0];
      end
    end else begin
      nextCnt_s = cnt_r;
    end
  end

  // Counter, flag and shadow state; the shadow samples the pre-update count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= {CNT_W{1'b0}};
      shadow_r <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      cnt_r <= nextCnt_s;
      ovf_r <= nextOvf_s;
      if (snap) begin
        shadow_r <= cnt_r;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  assign cnt    = cnt_r;
  assign shadow = shadow_r;
  assign ovf    = ovf_r;

endmodule

// File: rtl/perf_counter_bank.sv
// Parametrised bank of performance counters with live/shadow read port.
// Optional overflow interrupt (ovf_irq, ovf_mask) when PERF_CNT_OVF_IRQ_EN is defined.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT  = DEF_NUM_CNT,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int INC_W    = DEF_INC_W,
  parameter int SATURATE = 0,
  parameter int ADDR_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr_all,
  input  logic [NUM_CNT*INC_W-1:0] inc,
  input  logic                     snap,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [CNT_W-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_shadow,
  output logic                     rd_valid,
  output logic [CNT_W-1:0]         rd_data,
  output logic [NUM_CNT-1:0]       ovf
`ifdef PERF_CNT_OVF_IRQ_EN
  ,
  input  logic [NUM_CNT-1:0]       ovf_mask,
  output logic                     ovf_irq
`endif
);

  logic [CNT_W-1:0]   cntVec_s    [NUM_CNT];
  logic [CNT_W-1:0]   shadowVec_s [NUM_CNT];
  logic [NUM_CNT-1:0] ovfVec_s;
  logic [CNT_W-1:0]   rdMux_s;
  logic [CNT_W-1:0]   rdData_r;
  logic               rdValid_r;

  for (genvar g = 0; g < NUM_CNT; g++) begin : gCell
    perf_counter_cell #(
      .CNT_W   (CNT_W),
      .INC_W   (INC_W),
      .ADDR_W  (ADDR_W),
      .IDX     (g),
      .SATURATE(SATURATE)
    ) uCell (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clrAll(clr_all),
      .inc   (inc[g*INC_W +: INC_W]),
      .snap  (snap),
      .wrEn  (wr_en),
      .wrAddr(wr_addr),
      .wrData(wr_data),
      .cnt   (cntVec_s[g]),
      .shadow(shadowVec_s[g]),
      .ovf   (ovfVec_s[g])
    );
  end

  // Read mux; addresses with no counter behind them fall through to zero.
  always_comb begin
    rdMux_s = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_CNT; i++) begin
      rdMux_s = rdMux_s | ((rd_addr == ADDR_W'(i)) ?
                           (rd_shadow ? shadowVec_s[i] : cntVec_s[i]) : {CNT_W{1'b0}});
    end
  end

  // Read response registers: one-cycle valid pulse, data held between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdValid_r <= 1'b0;
      rdData_r  <= {CNT_W{1'b0}};
    end else begin
      rdValid_r <= rd_en;
      if (rd_en) begin
        rdData_r <= rdMux_s;
      end else begin
        rdData_r <= rdData_r;
      end
    end
  end

  assign rd_valid = rdValid_r;
  assign rd_data  = rdData_r;
  assign ovf      = ovfVec_s;

`ifdef PERF_CNT_OVF_IRQ_EN
  logic ovfIrq_r;

  // Interrupt follows unmasked sticky flags one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovfIrq_r <= 1'b0;
    end else begin
      ovfIrq_r <= |(ovfVec_s & ~ovf_mask);
    end
  end

  assign ovf_irq = ovfIrq_r;
`endif

endmodule
